// File: rtl/call_stack.sv
// call_stack: CALL/RET decode with a hardware return-address stack; optional fault lock via CALL_STACK_FAULT_EN (the instruction type field is the port instr_type because "type" is a reserved word)
module call_stack #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               instr_type,
  input  logic [3:0]               opcode,
  input  logic [10:0]              call_addr,
  input  logic [18:0]              pc_current,
  input  logic                     program_end,
  output logic [18:0]              subroutine_pc_next,
  output logic                     subroutine_pc_src,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     stack_overflow,
  output logic                     stack_underflow,
  output logic                     stack_fault
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {RUN, FAULT} state_t;
  state_t state, state_nx;
  logic [18:0] mem [DEPTH];
  logic [CW-1:0] count;
  logic [18:0] pc_inc;
  logic is_call, is_ret, full, empty, push, pop, ovf_redirect;
  // decode, stack bookkeeping and same-cycle redirect selection
  always_comb begin
    pc_inc = pc_current + 19'd1;
    is_call = rst_n && !program_end && state == RUN && instr_type == 2'b10 && opcode == 4'b0101;
    is_ret = rst_n && !program_end && state == RUN && instr_type == 2'b10 && opcode == 4'b0110;
    full = count == CW'(DEPTH);
    empty = count == '0;
    push = is_call && !full;
    pop = is_ret && !empty;
    stack_overflow = is_call && full;
    stack_underflow = is_ret && empty;
`ifdef CALL_STACK_FAULT_EN
    ovf_redirect = 1'b0;
    state_nx = (stack_overflow || stack_underflow) ? FAULT : state;
`else
    ovf_redirect = stack_overflow;
    state_nx = RUN;
`endif
    subroutine_pc_src = push || pop || ovf_redirect;
    subroutine_pc_next = (push || ovf_redirect) ? {8'd0, call_addr} :
                         pop ? mem[AW'(count - CW'(1))] : pc_inc;
    depth = count;
    stack_fault = state == FAULT;
  end
  // stack pointer and fault state; reset clears pending returns
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      state <= RUN;
    end else begin
      state <= state_nx;
      count <= push ? count + CW'(1) : pop ? count - CW'(1) : count;
    end
  end
  // return-address storage, left untouched by reset
  always_ff @(posedge clk) begin
    if (push) mem[AW'(count)] <= pc_inc;
  end
endmodule

// File: tb/tb_call_stack.sv
// tb_call_stack: randomized and directed checks of call_stack against a queue-based model
module tb_call_stack;
  localparam int D = 8;
`ifdef CALL_STACK_FAULT_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] instr_type = '0;
  logic [3:0] opcode = '0;
  logic [10:0] call_addr = '0;
  logic [18:0] pc_current = '0;
  logic program_end = 1'b0;
  logic [18:0] subroutine_pc_next;
  logic subroutine_pc_src;
  logic [$clog2(D):0] depth;
  logic stack_overflow, stack_underflow, stack_fault;
  int n_cmp = 0;
  int n_bad = 0;
  logic [18:0] q [$];
  bit fault = 1'b0;

  call_stack #(.DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .instr_type(instr_type), .opcode(opcode),
    .call_addr(call_addr), .pc_current(pc_current), .program_end(program_end),
    .subroutine_pc_next(subroutine_pc_next), .subroutine_pc_src(subroutine_pc_src),
    .depth(depth), .stack_overflow(stack_overflow), .stack_underflow(stack_underflow),
    .stack_fault(stack_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic [1:0] t, input logic [3:0] o,
                     input logic [10:0] a, input logic [18:0] p, input logic e);
    bit act, call, ret, ovf, udf, src;
    logic [18:0] nxt, ret_addr;
    int sz;
    rst_n = r; instr_type = t; opcode = o; call_addr = a; pc_current = p; program_end = e;
    #1;
    sz = q.size();
    act = r && !e && !fault;
    call = act && t == 2'b10 && o == 4'b0101;
    ret = act && t == 2'b10 && o == 4'b0110;
    ovf = call && sz == D;
    udf = ret && sz == 0;
    ret_addr = 19'(p + 1);
    src = 1'b0;
    nxt = ret_addr;
    if (call && (sz < D || !FEN)) begin src = 1'b1; nxt = {8'd0, a}; end
    if (ret && sz > 0) begin src = 1'b1; nxt = q[$]; end
    check("pc_src", 32'(subroutine_pc_src), 32'(src));
    check("pc_next", 32'(subroutine_pc_next), 32'(nxt));
    check("overflow", 32'(stack_overflow), 32'(ovf));
    check("underflow", 32'(stack_underflow), 32'(udf));
    check("depth", 32'(depth), 32'(sz));
    check("fault", 32'(stack_fault), 32'(fault));
    @(posedge clk);
    #1;
    if (!r) begin
      q.delete();
      fault = 1'b0;
    end else begin
      if (call && sz < D) q.push_back(ret_addr);
      if (ret && sz > 0) void'(q.pop_back());
      if (FEN && (ovf || udf)) fault = 1'b1;
    end
  endtask

  task automatic call_i(input logic [10:0] a, input logic [18:0] p);
    cyc(1'b1, 2'b10, 4'b0101, a, p, 1'b0);
  endtask

  task automatic ret_i(input logic [18:0] p);
    cyc(1'b1, 2'b10, 4'b0110, 11'h0, p, 1'b0);
  endtask

  task automatic rst_i();
    cyc(1'b0, 2'b10, 4'b0110, 11'h0, 19'd100, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_i();
    call_i(11'h40, 19'd10);
    ret_i(19'd64);
    call_i(11'h1, 19'd5);
    call_i(11'h2, 19'd20);
    call_i(11'h3, 19'd35);
    ret_i(19'd50);
    ret_i(19'd51);
    ret_i(19'd52);
    ret_i(19'd60);
    call_i(11'h5, 19'd61);
    rst_i();
    for (int i = 0; i < D; i++) call_i(11'(i), 19'(100 + i));
    call_i(11'h7FF, 19'd200);
    ret_i(19'd201);
    rst_i();
    cyc(1'b1, 2'b10, 4'b0101, 11'h9, 19'd7, 1'b1);
    call_i(11'h9, 19'h7FFFF);
    ret_i(19'd3);
    call_i(11'h1, 19'd1);
    call_i(11'h2, 19'd2);
    call_i(11'h3, 19'd3);
    rst_i();
    ret_i(19'd9);
    rst_i();
    for (int i = 0; i < 600; i++) begin
      int k;
      logic [1:0] t;
      logic [3:0] o;
      k = $urandom_range(0, 99);
      t = 2'b10;
      o = k < 45 ? 4'b0101 : k < 85 ? 4'b0110 : 4'($urandom);
      if (k >= 95) t = 2'($urandom);
      cyc($urandom_range(0, 49) != 0, t, o, 11'($urandom), 19'($urandom), $urandom_range(0, 19) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
